// File: rtl/ysyx_22040088_ifu_pkg.sv
// Shared definitions for the instruction fetch unit: FSM state encoding,
// instruction width and the default reset PC.
package ysyx_22040088_ifu_pkg;

  typedef enum logic [2:0] {
    S_REQ   = 3'd0,
    S_WAIT  = 3'd1,
    S_OUT   = 3'd2,
    S_EXEC  = 3'd3,
    S_FAULT = 3'd4
  } state_t;

  localparam int          INST_W           = 32;
  localparam logic [63:0] RESET_PC_DEFAULT = 64'h0000_0000_8000_0000;

  // Instructions are 4-byte aligned; any low address bit set is a fault.
  function automatic logic misaligned(input logic [1:0] lsb);
    return lsb != 2'b00;
  endfunction

endpackage

// File: rtl/ysyx_22040088_ifu_reg.sv
// Generic write-enabled register with asynchronous active-low reset,
// used for the architectural PC and the fetched instruction word.
module ysyx_22040088_reg #(
  parameter int           W       = 64,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         we,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= RST_VAL;
    end else if (we) begin
      q <= d;
    end
  end

endmodule

// File: rtl/ysyx_22040088_ifu.sv
// Instruction fetch unit: owns the PC, fetches one instruction per retired
// instruction over a valid/ready memory port, non-pipelined.
module ysyx_22040088_ifu
  import ysyx_22040088_ifu_pkg::*;
#(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT[XLEN-1:0]
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [XLEN-1:0]   imem_req_addr,
  input  logic              imem_resp_valid,
  input  logic [INST_W-1:0] imem_resp_data,
  input  logic              imem_resp_err,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst,
  output logic [XLEN-1:0]   inst_pc,
  output logic [XLEN-1:0]   pcadd,
  input  logic              commit_valid,
  input  logic [XLEN-1:0]   nextpc,
  output logic              fetch_fault
);

  state_t            state_reg;
  logic              req_valid_reg;
  logic              inst_valid_reg;
  logic              fault_reg;
  logic [XLEN-1:0]   pc;
  logic [INST_W-1:0] inst_q;

  logic req_fire;
  logic resp_ok;
  logic commit_fire;
  logic commit_bad;

  assign req_fire    = (state_reg == S_REQ) && req_valid_reg && imem_req_ready;
  assign resp_ok     = (state_reg == S_WAIT) && imem_resp_valid && !imem_resp_err;
  // Commit is only meaningful while the current instruction is being handed
  // to decode or is executing; anywhere else it is ignored.
  assign commit_fire = ((state_reg == S_OUT) && inst_ready && commit_valid) ||
                       ((state_reg == S_EXEC) && commit_valid);
  assign commit_bad  = misaligned(nextpc[1:0]);

  ysyx_22040088_reg #(.W(XLEN), .RST_VAL(RESET_PC)) u_pc (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (commit_fire),
    .d     (nextpc),
    .q     (pc)
  );

  ysyx_22040088_reg #(.W(INST_W), .RST_VAL('0)) u_inst (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (resp_ok),
    .d     (imem_resp_data),
    .q     (inst_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= S_REQ;
      req_valid_reg  <= 1'b0;
      inst_valid_reg <= 1'b0;
      fault_reg      <= 1'b0;
    end else begin
      case (state_reg)
        S_REQ: begin
          if (req_fire) begin
            req_valid_reg <= 1'b0;
            state_reg     <= S_WAIT;
          end else begin
            req_valid_reg <= 1'b1;
          end
        end
        S_WAIT: begin
          if (imem_resp_valid) begin
            if (imem_resp_err) begin
              state_reg <= S_FAULT;
              fault_reg <= 1'b1;
            end else begin
              state_reg      <= S_OUT;
              inst_valid_reg <= 1'b1;
            end
          end
        end
        S_OUT: begin
          if (inst_ready) begin
            inst_valid_reg <= 1'b0;
            state_reg      <= S_EXEC;
          end
        end
        S_EXEC: begin
          inst_valid_reg <= 1'b0;
        end
        default: begin
          state_reg      <= S_FAULT;
          req_valid_reg  <= 1'b0;
          inst_valid_reg <= 1'b0;
          fault_reg      <= 1'b1;
        end
      endcase
      // Placed after the case so a same-cycle commit overrides the S_OUT -> S_EXEC step.
      if (commit_fire) begin
        if (commit_bad) begin
          state_reg <= S_FAULT;
          fault_reg <= 1'b1;
        end else begin
          state_reg     <= S_REQ;
          req_valid_reg <= 1'b1;
        end
      end
    end
  end

  assign imem_req_valid = req_valid_reg;
  assign imem_req_addr  = pc;
  assign inst_valid     = inst_valid_reg;
  assign inst           = inst_q;
  assign inst_pc        = pc;
  assign pcadd          = pc + XLEN'(4);
  assign fetch_fault    = fault_reg;

endmodule

// File: tb/tb_ysyx_22040088_ifu.sv
// Directed bench for the fetch unit: expected fetch addresses and decoded
// instructions go through scoreboard queues and are checked as the DUT emits them.
module tb_ysyx_22040088_ifu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        imem_resp_err;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic [63:0] pcadd;
  logic        commit_valid;
  logic [63:0] nextpc;
  logic        fetch_fault;

  typedef struct packed {
    logic [31:0] word;
    logic [63:0] pc;
  } exp_inst_t;

  logic [63:0] exp_addr_q[$];
  exp_inst_t   exp_inst_q[$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ysyx_22040088_ifu dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .imem_resp_err   (imem_resp_err),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .inst            (inst),
    .inst_pc         (inst_pc),
    .pcadd           (pcadd),
    .commit_valid    (commit_valid),
    .nextpc          (nextpc),
    .fetch_fault     (fetch_fault)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Memory side: wait for a request, optionally stall it, accept, respond.
  task automatic fetch(input logic [31:0] data, input logic err, input int hold);
    int n;
    logic [63:0] a;
    logic [63:0] exp_a;
    n = 0;
    while (!imem_req_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("req_seen", {63'd0, imem_req_valid}, 64'd1);
    a = imem_req_addr;
    for (int i = 0; i < hold; i++) begin
      commit_valid = 1'b1;            // stray commit while fetching must be ignored
      nextpc       = 64'h0000_0000_0000_1230;
      @(negedge clk);
      check("req_hold_valid", {63'd0, imem_req_valid}, 64'd1);
      check("req_hold_addr", imem_req_addr, a);
    end
    commit_valid = 1'b0;
    exp_a = (exp_addr_q.size() > 0) ? exp_addr_q.pop_front() : 64'hDEAD_DEAD_DEAD_DEAD;
    check("req_addr", a, exp_a);
    imem_req_ready = 1'b1;
    @(negedge clk);
    imem_req_ready = 1'b0;
    check("req_drop", {63'd0, imem_req_valid}, 64'd0);
    imem_resp_valid = 1'b1;
    imem_resp_data  = data;
    imem_resp_err   = err;
    @(negedge clk);
    imem_resp_valid = 1'b0;
    imem_resp_err   = 1'b0;
    if (!err) exp_inst_q.push_back('{word: data, pc: exp_a});
    $display("fetch addr=%h data=%h err=%0d", a, data, err);
  endtask

  // Decode/commit side: accept the instruction, commit now or after delay cycles.
  task automatic consume(input int delay, input logic [63:0] npc);
    int n;
    exp_inst_t e;
    n = 0;
    while (!inst_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("inst_valid", {63'd0, inst_valid}, 64'd1);
    e = (exp_inst_q.size() > 0) ? exp_inst_q.pop_front() : '0;
    check("inst", {32'd0, inst}, {32'd0, e.word});
    check("inst_pc", inst_pc, e.pc);
    check("pcadd", pcadd, e.pc + 64'd4);
    if (npc[1:0] == 2'b00) exp_addr_q.push_back(npc);
    inst_ready = 1'b1;
    nextpc     = npc;
    commit_valid = (delay == 0);
    @(negedge clk);
    inst_ready   = 1'b0;
    commit_valid = 1'b0;
    check("inst_valid_drop", {63'd0, inst_valid}, 64'd0);
    if (delay > 0) begin
      repeat (delay) begin
        @(negedge clk);
        check("exec_no_req", {63'd0, imem_req_valid}, 64'd0);
      end
      commit_valid = 1'b1;
      @(negedge clk);
      commit_valid = 1'b0;
    end
    $display("commit pc=%h inst=%h nextpc=%h delay=%0d", e.pc, e.word, npc, delay);
  endtask

  task automatic check_fault(input int cycles);
    repeat (cycles) begin
      @(negedge clk);
      check("fault_flag", {63'd0, fetch_fault}, 64'd1);
      check("fault_no_req", {63'd0, imem_req_valid}, 64'd0);
      check("fault_no_inst", {63'd0, inst_valid}, 64'd0);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    check("rst_req_valid", {63'd0, imem_req_valid}, 64'd0);
    check("rst_inst_valid", {63'd0, inst_valid}, 64'd0);
    check("rst_fault", {63'd0, fetch_fault}, 64'd0);
    check("rst_pc", inst_pc, 64'h0000_0000_8000_0000);
    check("rst_inst", {32'd0, inst}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    exp_addr_q.delete();
    exp_inst_q.delete();
    exp_addr_q.push_back(64'h0000_0000_8000_0000);
    $display("reset released");
  endtask

  initial begin
    rst_n = 1'b1;
    imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0; imem_resp_err = 1'b0;
    inst_ready = 1'b0; commit_valid = 1'b0; nextpc = '0;
    @(negedge clk);
    do_reset();

    // Reset release, first fetch, then commit from S_EXEC with nextpc = pcadd.
    fetch(32'h0000_0013, 1'b0, 0);
    consume(2, 64'h0000_0000_8000_0004);
    // Stalled request, then single-cycle commit to a branch target.
    fetch(32'h0010_0093, 1'b0, 3);
    consume(0, 64'h0000_0000_8000_0100);
    fetch(32'h0020_0113, 1'b0, 1);
    // Jump to the top of the address space: pcadd must wrap to zero.
    consume(0, 64'hFFFF_FFFF_FFFF_FFFC);
    fetch(32'h0030_0193, 1'b0, 0);
    consume(1, 64'h0000_0000_8000_0008);
    // Access fault on response.
    fetch(32'hFFFF_FFFF, 1'b1, 0);
    check_fault(4);

    // Reset while waiting for a response; the late response must be ignored.
    do_reset();
    fetch_req_only: begin
      int n;
      n = 0;
      while (!imem_req_valid && n < 20) begin
        @(negedge clk);
        n++;
      end
      check("wait_req_seen", {63'd0, imem_req_valid}, 64'd1);
      imem_req_ready = 1'b1;
      @(negedge clk);
      imem_req_ready = 1'b0;
    end
    do_reset();
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'hBAD0_BAD0;
    @(negedge clk);
    imem_resp_valid = 1'b0;
    check("stale_no_inst", {63'd0, inst_valid}, 64'd0);
    check("stale_pc", inst_pc, 64'h0000_0000_8000_0000);
    fetch(32'h0040_0213, 1'b0, 0);
    // Misaligned commit target faults without issuing a request.
    consume(0, 64'h0000_0000_8000_0102);
    check("misalign_pc", inst_pc, 64'h0000_0000_8000_0102);
    check_fault(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
